latch_bank_arbiter: RTL and testbench

LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

---
 rtl/latch_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_latch_bank_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_arbiter.sv
// Two-requester round-robin arbiter sequencing writes into a bank of transparent latches.
// Each write runs SETUP -> OPEN (ENA_CYCLES) -> HOLD so the latch enable never overlaps a data change.
module latch_bank_arbiter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_LATCH  = 4,
    parameter int unsigned ENA_CYCLES = 2,
    localparam int unsigned AW        = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [AW-1:0]        addr0,
    input  logic [AW-1:0]        addr1,
    input  logic [WIDTH-1:0]     data0,
    input  logic [WIDTH-1:0]     data1,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic [NUM_LATCH-1:0] latch_ena,
    output logic [WIDTH-1:0]     latch_d,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_OPEN,
        ST_HOLD
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ENA_CYCLES - 1);

    state_t               r_state;
    logic [1:0]           r_gnt;
    logic [1:0]           r_done;
    logic [NUM_LATCH-1:0] r_ena;
    logic [WIDTH-1:0]     r_d;
    logic [AW-1:0]        r_addr;
    logic [3:0]           r_cnt;
    logic                 r_ptr;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [1:0]           w_gnt_nxt;
    logic [1:0]           w_done_nxt;
    logic [NUM_LATCH-1:0] w_ena_nxt;
    logic [WIDTH-1:0]     w_d_nxt;
    logic [AW-1:0]        w_addr_nxt;
    logic [3:0]           w_cnt_nxt;
    logic                 w_ptr_nxt;
    logic                 w_busy_nxt;
    logic                 w_win;
    logic [NUM_LATCH-1:0] w_sel_ena;

    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    assign w_win = req1 & (~req0 | r_ptr);

    always_comb begin
        w_sel_ena = '0;
        for (int unsigned i = 0; i < NUM_LATCH; i++) begin
            if (r_addr == AW'(i)) begin
                w_sel_ena[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_ena_nxt   = '0;
        w_d_nxt     = r_d;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_busy_nxt  = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (req0 | req1) begin
                    w_state_nxt = ST_SETUP;
                    w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
                    w_addr_nxt  = w_win ? addr1 : addr0;
                    w_d_nxt     = w_win ? data1 : data0;
                    w_ptr_nxt   = ~w_win;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_OPEN;
                w_cnt_nxt   = CNT_INIT;
                w_ena_nxt   = w_sel_ena;
            end
            ST_OPEN: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_HOLD;
                    w_done_nxt  = r_gnt;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    w_ena_nxt = w_sel_ena;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_ena   <= '0;
            r_d     <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_ena   <= w_ena_nxt;
            r_d     <= w_d_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign latch_ena = r_ena;
    assign latch_d   = r_d;
    assign busy      = r_busy;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: transaction-level reference model checked every cycle,
// directed scenarios plus randomized two-requester traffic into a behavioural latch bank.
module tb_latch_bank_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int ENA = 2;

    logic         clk = 1'b0;
    logic         areset_n;
    logic [1:0]   req;
    logic [1:0]   addr [2];
    logic [W-1:0] data [2];
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [N-1:0] latch_ena;
    logic [W-1:0] latch_d;
    logic         busy;
    logic         chk_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    latch_bank_arbiter #(
        .WIDTH      (W),
        .NUM_LATCH  (N),
        .ENA_CYCLES (ENA)
    ) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .req0      (req[0]),
        .req1      (req[1]),
        .addr0     (addr[0]),
        .addr1     (addr[1]),
        .data0     (data[0]),
        .data1     (data[1]),
        .gnt       (gnt),
        .done      (done),
        .latch_ena (latch_ena),
        .latch_d   (latch_d),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural transparent latch bank driven by the DUT outputs.
    logic [W-1:0] bank [N];
    always @(latch_ena or latch_d) begin
        for (int i = 0; i < N; i++) begin
            if (latch_ena[i]) bank[i] = latch_d;
        end
    end

    // Reference model: one transaction at a time, age counted in cycles since the grant edge.
    logic         m_busy;
    int           m_age;
    logic         m_win;
    logic [1:0]   m_addr;
    logic [W-1:0] m_d;
    logic         m_ptr;
    logic [W-1:0] exp_mem [N];
    logic         written [N];
    int           completions = 0;

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_win  = 1'b0;
            m_addr = '0;
            m_d    = '0;
            m_ptr  = 1'b0;
            for (int i = 0; i < N; i++) written[i] = 1'b0;
        end else if (!m_busy) begin
            if (req != 2'b00) begin
                m_win  = (req == 2'b11) ? m_ptr : req[1];
                m_ptr  = !m_win;
                m_addr = addr[m_win];
                m_d    = data[m_win];
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (m_age == ENA + 1) begin
            m_busy = 1'b0;
            exp_mem[m_addr] = m_d;
            written[m_addr] = 1'b1;
            completions++;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        logic [1:0]   eg;
        logic [N-1:0] ee;
        logic [1:0]   ed;
        if (chk_en) begin
            eg = m_busy ? (m_win ? 2'b10 : 2'b01) : 2'b00;
            ee = (m_busy && m_age >= 1 && m_age <= ENA) ? (4'b0001 << m_addr) : 4'b0000;
            ed = (m_busy && m_age == ENA + 1) ? eg : 2'b00;
            check("gnt", 32'(gnt), 32'(eg));
            check("done", 32'(done), 32'(ed));
            check("latch_ena", 32'(latch_ena), 32'(ee));
            check("latch_d", 32'(latch_d), 32'(m_d));
            check("busy", 32'(busy), 32'(m_busy));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        req = 2'b00;
        #2 areset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 areset_n = 1'b1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (done != 2'b00) ok = 1'b1;
        end
        if (!ok) check("timeout_done", 0, 1);
    endtask

    task automatic wait_ena(input logic [N-1:0] pat, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (latch_ena == pat) ok = 1'b1;
        end
        if (!ok) check("timeout_ena", 0, 1);
    endtask

    task automatic rand_step();
        for (int i = 0; i < 2; i++) begin
            if (req[i] && done[i]) begin
                req[i] = 1'b0;
            end else if (req[i] && gnt[i]) begin
                if ($urandom_range(0, 5) == 0) begin
                    addr[i] = 2'($urandom);
                    data[i] = 8'($urandom);
                end else if ($urandom_range(0, 40) == 0) begin
                    req[i] = 1'b0;
                end
            end else if (!req[i] && !gnt[i] && $urandom_range(0, 2) == 0) begin
                req[i]  = 1'b1;
                addr[i] = 2'($urandom);
                data[i] = 8'($urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  ngnt, nena, nw, gaps, c0;
        bit  ok, got;
        logic [1:0] prev;

        chk_en   = 1'b0;
        req      = 2'b00;
        addr[0]  = '0;
        addr[1]  = '0;
        data[0]  = '0;
        data[1]  = '0;
        areset_n = 1'b0;

        #12;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ena", 32'(latch_ena), 0);
        check("rst_d", 32'(latch_d), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        #2 areset_n = 1'b1;
        chk_en = 1'b1;

        // Single write, latency and enable width
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 2'd2; data[0] = 8'hA5;
        ngnt = 0; nena = 0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) ngnt++;
            if (latch_ena == 4'b0100) nena++;
            if (done == 2'b01) begin
                got = 1'b1;
                check("t1_d", 32'(latch_d), 32'h A5);
                req[0] = 1'b0;
            end
        end
        check("t1_done_seen", 32'(got), 1);
        check("t1_latency", ngnt, 2 + ENA);
        check("t1_ena_cycles", nena, ENA);
        repeat (3) @(negedge clk);

        // Simultaneous and continuous requests: alternating grants, one idle cycle between
        do_reset();
        @(negedge clk);
        req = 2'b11;
        addr[0] = 2'd1; data[0] = 8'hA1;
        addr[1] = 2'd3; data[1] = 8'h1B;
        nw = 0; gaps = 0; prev = 2'b00;
        for (int k = 0; k < 200 && nw < 6; k++) begin
            @(negedge clk);
            if (gnt != 2'b00 && prev == 2'b00) begin
                check($sformatf("fair_%0d", nw), 32'(gnt), (nw % 2) ? 2'b10 : 2'b01);
                nw++;
            end else if (gnt == 2'b00 && nw > 0) begin
                gaps++;
            end
            prev = gnt;
        end
        check("fair_count", nw, 6);
        check("fair_gaps", gaps, 5);
        wait_done(ok);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Data and address change during OPEN have no effect
        req[0] = 1'b1; addr[0] = 2'd1; data[0] = 8'h3C;
        wait_ena(4'b0010, ok);
        data[0] = 8'hFF; addr[0] = 2'd3;
        wait_done(ok);
        check("mid_d", 32'(latch_d), 32'h3C);
        check("mid_done", 32'(done), 32'b01);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during OPEN drops enable at once, no done for aborted write
        req[0] = 1'b1; addr[0] = 2'd0; data[0] = 8'h5A;
        wait_ena(4'b0001, ok);
        #2 areset_n = 1'b0;
        #1;
        check("abort_ena", 32'(latch_ena), 0);
        check("abort_gnt", 32'(gnt), 0);
        check("abort_done", 32'(done), 0);
        check("abort_busy", 32'(busy), 0);
        req[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 0);
        end
        #2 areset_n = 1'b1;
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 2'd0; data[0] = 8'h77;
        wait_done(ok);
        check("post_abort_d", 32'(latch_d), 32'h77);
        check("post_abort_done", 32'(done), 32'b01);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic into the latch bank
        do_reset();
        c0 = completions;
        for (int k = 0; k < 20000 && (completions - c0) < 100; k++) begin
            @(negedge clk);
            rand_step();
        end
        check("rand_writes", 32'((completions - c0) >= 100), 1);
        req = 2'b00;
        repeat (10) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (written[i]) check($sformatf("bank_%0d", i), 32'(bank[i]), 32'(exp_mem[i]));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
